// File: rtl/apb_sample_player.sv
`timescale 1ns/1ps
// apb_sample_player: APB slave that queues firmware-written audio samples in a FIFO and
//   plays them at DIV+1 PCLK cycles per sample through a 1-bit first-order sigma-delta DAC.
// Latency: register writes land on the access-phase edge, PRDATA is combinational,
//   a pushed sample reaches cur_sample on the next divider tick, and IRQ follows its cause by 1 cycle.
// Backpressure: PREADY is tied high. A push to a full FIFO with no pop in that cycle is dropped,
//   answered with PSLVERR and recorded in the sticky OVF flag.
// Ports: PCLK/PRESERN clock and async active-low reset; PSEL/PENABLE/PWRITE/PADDR/PWDATA APB request;
//   PRDATA/PREADY/PSLVERR APB response; DAC_OUT sigma-delta bitstream; IRQ registered level interrupt.
module apb_sample_player #(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 64,
  parameter int DIV_W    = 16
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        DAC_OUT,
  output logic        IRQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_DIV   = 3'd1;
  localparam logic [2:0] A_DATA  = 3'd2;
  localparam logic [2:0] A_STAT  = 3'd3;
  localparam logic [2:0] A_LOWWM = 3'd4;

  // Register state
  logic                en_q, en_d;
  logic                irq_en_q, irq_en_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CW-1:0]       lowwm_q, lowwm_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SAMPLE_W-1:0] cur_sample_q, cur_sample_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic                underrun_q, underrun_d;
  logic                ovf_q, ovf_d;
  logic                dac_q, dac_d;
  logic                irq_q, irq_d;

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Decode
  logic [2:0] reg_idx;
  logic       wr_en;
  logic       ctrl_wr, div_wr, data_wr, stat_wr, lowwm_wr;
  logic       flush;

  assign reg_idx  = PADDR[4:2];
  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign ctrl_wr  = wr_en && (reg_idx == A_CTRL);
  assign div_wr   = wr_en && (reg_idx == A_DIV);
  assign data_wr  = wr_en && (reg_idx == A_DATA);
  assign stat_wr  = wr_en && (reg_idx == A_STAT);
  assign lowwm_wr = wr_en && (reg_idx == A_LOWWM);
  assign flush    = ctrl_wr & PWDATA[1];

  // FIFO status and event qualification
  logic empty, full, low, tick, pop, push_ok, ovf_set, underrun_set;
  logic [SAMPLE_W:0] sd_sum;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign low   = (count_q <= lowwm_q);
  assign tick  = en_q && (div_cnt_q == div_q);

  // A flush on a tick edge wins: the tick neither pops nor reports underrun.
  assign pop          = tick & ~empty & ~flush;
  assign underrun_set = tick & empty & ~flush;
  // A simultaneous pop frees the slot, so a push to a full FIFO is still accepted.
  assign push_ok      = data_wr & (~full | pop);
  assign ovf_set      = data_wr & full & ~pop;

  assign sd_sum = {1'b0, acc_q} + {1'b0, cur_sample_q};

  always_comb begin
    en_d         = en_q;
    irq_en_d     = irq_en_q;
    div_d        = div_q;
    lowwm_d      = lowwm_q;
    div_cnt_d    = div_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    cur_sample_d = cur_sample_q;
    acc_d        = '0;
    dac_d        = 1'b0;

    if (ctrl_wr) begin
      en_d     = PWDATA[0];
      irq_en_d = PWDATA[2];
    end
    if (div_wr)   div_d   = PWDATA[DIV_W-1:0];
    if (lowwm_wr) lowwm_d = PWDATA[CW-1:0];

    // Divider: any DIV write restarts the sample period.
    if (!en_q || div_wr || tick) div_cnt_d = '0;
    else                         div_cnt_d = div_cnt_q + DIV_W'(1);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_ok) count_d = count_q - CW'(1);
    end

    if (pop) cur_sample_d = mem[rd_ptr_q];

    if (en_q) begin
      acc_d = sd_sum[SAMPLE_W-1:0];
      dac_d = sd_sum[SAMPLE_W];
    end

    // Sticky flags: a set in the same cycle as a write-1 clear keeps the bit at 1.
    underrun_d = underrun_set | (underrun_q & ~(stat_wr & PWDATA[3]));
    ovf_d      = ovf_set      | (ovf_q      & ~(stat_wr & PWDATA[4]));

    irq_d = irq_en_q & (low | underrun_q | ovf_q);
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      en_q         <= 1'b0;
      irq_en_q     <= 1'b0;
      div_q        <= '0;
      lowwm_q      <= '0;
      div_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_sample_q <= {1'b1, {(SAMPLE_W-1){1'b0}}};
      acc_q        <= '0;
      underrun_q   <= 1'b0;
      ovf_q        <= 1'b0;
      dac_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      irq_en_q     <= irq_en_d;
      div_q        <= div_d;
      lowwm_q      <= lowwm_d;
      div_cnt_q    <= div_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_sample_q <= cur_sample_d;
      acc_q        <= acc_d;
      underrun_q   <= underrun_d;
      ovf_q        <= ovf_d;
      dac_q        <= dac_d;
      irq_q        <= irq_d;
    end
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr_q] <= PWDATA[SAMPLE_W-1:0];
  end

  // Read mux
  logic [31:0] status;
  always_comb begin
    status        = '0;
    status[0]     = empty;
    status[1]     = full;
    status[2]     = low;
    status[3]     = underrun_q;
    status[4]     = ovf_q;
    status[8 +: CW] = count_q;
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (reg_idx)
        A_CTRL: begin
          PRDATA[0] = en_q;
          PRDATA[2] = irq_en_q;
        end
        A_DIV:   PRDATA[DIV_W-1:0] = div_q;
        A_STAT:  PRDATA = status;
        A_LOWWM: PRDATA[CW-1:0] = lowwm_q;
        default: PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = ovf_set;
  assign DAC_OUT = dac_q;
  assign IRQ     = irq_q;

  // Address bits outside PADDR[4:2] and the upper write-data bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^{PADDR[7:5], PADDR[1:0], PWDATA};

endmodule
